// File: rtl/exec_seq_pkg.sv
// Shared types and default widths for the exec_sequencer block.
package exec_seq_pkg;

    localparam int PC_WIDTH_DEF  = 10;
    localparam int OFF_WIDTH_DEF = 6;
    localparam int CNT_WIDTH_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALTED
    } seq_state_t;

endpackage

// File: rtl/exec_sequencer_pc_next.sv
// pc_next_calc: combinational next-PC selection (jump > taken branch > increment),
// all arithmetic wraps modulo 2^PC_WIDTH.
module pc_next_calc
    import exec_seq_pkg::*;
#(
    parameter int PC_WIDTH  = PC_WIDTH_DEF,
    parameter int OFF_WIDTH = OFF_WIDTH_DEF
) (
    input  logic [PC_WIDTH-1:0]  pc,
    input  logic                 jump,
    input  logic                 branch,
    input  logic                 take_branch,
    input  logic [PC_WIDTH-1:0]  jump_target,
    input  logic [OFF_WIDTH-1:0] branch_off,
    output logic [PC_WIDTH-1:0]  pc_next
);

    logic [PC_WIDTH-1:0] off_ext;

    always_comb begin
        off_ext = {{(PC_WIDTH - OFF_WIDTH){branch_off[OFF_WIDTH-1]}}, branch_off};
        if (jump) begin
            pc_next = jump_target;
        end else if (branch && take_branch) begin
            pc_next = pc + off_ext;
        end else begin
            pc_next = pc + PC_WIDTH'(1);
        end
    end

endmodule

// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer that owns the
// program counter and a saturating retired-instruction counter.
module exec_sequencer
    import exec_seq_pkg::*;
#(
    parameter int PC_WIDTH  = PC_WIDTH_DEF,
    parameter int OFF_WIDTH = OFF_WIDTH_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    output logic                 fetch_req,
    input  logic                 instr_valid,
    output logic                 ir_load,
    output logic [PC_WIDTH-1:0]  pc,
    input  logic                 branch,
    input  logic                 jump,
    input  logic                 halt,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic                 take_branch,
    input  logic [PC_WIDTH-1:0]  jump_target,
    input  logic [OFF_WIDTH-1:0] branch_off,
    output logic                 dmem_req,
    input  logic                 dmem_ready,
    output logic                 reg_write,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] retired
);

    seq_state_t           state, next_state;
    logic [PC_WIDTH-1:0]  pc_q, pc_next, target_q;
    logic [OFF_WIDTH-1:0] off_q;
    logic [CNT_WIDTH-1:0] retired_q;
    logic                 jump_q, branch_q, take_q, mem_write_q;
    logic                 restart, retire;

    assign restart = start && (state == IDLE || state == HALTED);
    assign retire  = (state == WB) || (state == EXEC && halt);
    assign pc      = pc_q;
    assign retired = retired_q;

    pc_next_calc #(
        .PC_WIDTH  (PC_WIDTH),
        .OFF_WIDTH (OFF_WIDTH)
    ) u_pc_next (
        .pc          (pc_q),
        .jump        (jump_q),
        .branch      (branch_q),
        .take_branch (take_q),
        .jump_target (target_q),
        .branch_off  (off_q),
        .pc_next     (pc_next)
    );

    // Decoder strobes are snapshotted in EXEC so WB is immune to changes during MEM.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            pc_q        <= '0;
            retired_q   <= '0;
            jump_q      <= 1'b0;
            branch_q    <= 1'b0;
            take_q      <= 1'b0;
            mem_write_q <= 1'b0;
            target_q    <= '0;
            off_q       <= '0;
        end else begin
            state <= next_state;
            if (state == EXEC) begin
                jump_q      <= jump;
                branch_q    <= branch;
                take_q      <= take_branch;
                mem_write_q <= mem_write;
                target_q    <= jump_target;
                off_q       <= branch_off;
            end
            if (restart) begin
                pc_q      <= '0;
                retired_q <= '0;
            end else begin
                if (state == WB) begin
                    pc_q <= pc_next;
                end
                if (retire && retired_q != '1) begin
                    retired_q <= retired_q + CNT_WIDTH'(1);
                end
            end
        end
    end

    always_comb begin
        next_state = state;
        fetch_req  = 1'b0;
        ir_load    = 1'b0;
        dmem_req   = 1'b0;
        reg_write  = 1'b0;
        halted     = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = FETCH;
            end
            FETCH: begin
                fetch_req = 1'b1;
                if (instr_valid) begin
                    ir_load    = 1'b1;
                    next_state = DECODE;
                end
            end
            DECODE: begin
                next_state = EXEC;
            end
            EXEC: begin
                if (halt) begin
                    next_state = HALTED;
                end else if (mem_read || mem_write) begin
                    next_state = MEM;
                end else begin
                    next_state = WB;
                end
            end
            MEM: begin
                dmem_req = 1'b1;
                if (dmem_ready) next_state = WB;
            end
            WB: begin
                reg_write  = !(branch_q || jump_q || mem_write_q);
                next_state = FETCH;
            end
            HALTED: begin
                halted = 1'b1;
                if (start) next_state = FETCH;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: a transaction-level model predicts every
// output each cycle; a 3-bit-counter twin instance exercises saturation.
module tb_exec_sequencer;
    import exec_seq_pkg::*;

    typedef struct {
        logic       halt, mem_read, mem_write, branch, jump, take, rst_in_mem;
        logic [9:0] target;
        logic [5:0] off;
        int         fetch_wait, mem_wait;
    } instr_t;

    logic        clk = 1'b0;
    logic        reset_n, start, instr_valid, dmem_ready;
    logic        branch, jump, halt, mem_read, mem_write, take_branch;
    logic [9:0]  jump_target;
    logic [5:0]  branch_off;
    logic        fetch_req, ir_load, dmem_req, reg_write, halted;
    logic [9:0]  pc;
    logic [15:0] retired;
    logic        s_fetch_req, s_ir_load, s_dmem_req, s_reg_write, s_halted;
    logic [9:0]  s_pc;
    logic [2:0]  s_retired;

    logic        exp_fetch_req, exp_ir_load, exp_dmem_req, exp_reg_write, exp_halted;
    logic [9:0]  exp_pc, next_pc;
    int          exp_retired, next_ret;
    logic        check_en = 1'b0;
    int          vectors = 0, miscompares = 0, dmem_hi = 0, rw_hi = 0;
    instr_t      op;

    always #5 clk = ~clk;

    exec_sequencer dut (
        .clk(clk), .reset_n(reset_n), .start(start), .fetch_req(fetch_req),
        .instr_valid(instr_valid), .ir_load(ir_load), .pc(pc), .branch(branch),
        .jump(jump), .halt(halt), .mem_read(mem_read), .mem_write(mem_write),
        .take_branch(take_branch), .jump_target(jump_target), .branch_off(branch_off),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready), .reg_write(reg_write),
        .halted(halted), .retired(retired)
    );

    // Twin with a tiny counter so saturation at all-ones is reachable in a short run.
    exec_sequencer #(.CNT_WIDTH(3)) sat_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .fetch_req(s_fetch_req),
        .instr_valid(instr_valid), .ir_load(s_ir_load), .pc(s_pc), .branch(branch),
        .jump(jump), .halt(halt), .mem_read(mem_read), .mem_write(mem_write),
        .take_branch(take_branch), .jump_target(jump_target), .branch_off(branch_off),
        .dmem_req(s_dmem_req), .dmem_ready(dmem_ready), .reg_write(s_reg_write),
        .halted(s_halted), .retired(s_retired)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, want %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [9:0] modelNextPc(input logic [9:0] cur, input instr_t ins);
        int t;
        if (ins.jump) return ins.target;
        if (ins.branch && ins.take) begin
            t = int'(cur) + int'($signed(ins.off));
            return 10'((t + 1024) % 1024);
        end
        return 10'((int'(cur) + 1) % 1024);
    endfunction

    function automatic int satAdd(input int v, input int maxv);
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    function automatic instr_t nop();
        instr_t r;
        r.halt = 0; r.mem_read = 0; r.mem_write = 0; r.branch = 0; r.jump = 0;
        r.take = 0; r.rst_in_mem = 0; r.target = '0; r.off = '0;
        r.fetch_wait = 0; r.mem_wait = 0;
        return r;
    endfunction

    // Every cycle after reset the DUT outputs must match the model.
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("fetch_req", 32'(fetch_req), 32'(exp_fetch_req));
            checkOutput("ir_load", 32'(ir_load), 32'(exp_ir_load));
            checkOutput("dmem_req", 32'(dmem_req), 32'(exp_dmem_req));
            checkOutput("reg_write", 32'(reg_write), 32'(exp_reg_write));
            checkOutput("halted", 32'(halted), 32'(exp_halted));
            checkOutput("pc", 32'(pc), 32'(exp_pc));
            checkOutput("retired", 32'(retired), (exp_retired > 65535) ? 65535 : exp_retired);
            checkOutput("sat_retired", 32'(s_retired), (exp_retired > 7) ? 7 : exp_retired);
            checkOutput("sat_pc", 32'(s_pc), 32'(exp_pc));
            if (dmem_req) dmem_hi++;
            if (reg_write) rw_hi++;
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
        start = 0; instr_valid = 0; dmem_ready = 0; halt = 0; branch = 0; jump = 0;
        mem_read = 0; mem_write = 0; take_branch = 0; jump_target = '0; branch_off = '0;
        exp_fetch_req = 0; exp_ir_load = 0; exp_dmem_req = 0; exp_reg_write = 0;
    endtask

    task automatic settleFetch();
        nextCycle();
        exp_pc = next_pc; exp_retired = next_ret; exp_halted = 0; exp_fetch_req = 1;
    endtask

    task automatic scramble(input instr_t ins);
        jump = !ins.jump; branch = 1; take_branch = 1; mem_write = !ins.mem_write;
        halt = 1; jump_target = ~ins.target; branch_off = ~ins.off;
    endtask

    task automatic startRun();
        nextCycle();
        start = 1;
        next_pc = '0; next_ret = 0;
    endtask

    task automatic applyStimulus(input instr_t ins);
        settleFetch();
        for (int i = 0; i <= ins.fetch_wait; i++) begin
            if (i > 0) nextCycle();
            exp_fetch_req = 1;
            if (i == ins.fetch_wait) begin instr_valid = 1; exp_ir_load = 1; end
        end
        nextCycle();
        scramble(ins); instr_valid = 1; dmem_ready = 1;
        nextCycle();
        halt = ins.halt; mem_read = ins.mem_read; mem_write = ins.mem_write;
        branch = ins.branch; jump = ins.jump; take_branch = ins.take;
        jump_target = ins.target; branch_off = ins.off;
        if (ins.halt) begin
            nextCycle();
            exp_halted = 1; exp_retired = satAdd(exp_retired, 65535);
            return;
        end
        if (ins.mem_read || ins.mem_write) begin
            for (int i = 0; i <= ins.mem_wait; i++) begin
                nextCycle();
                exp_dmem_req = 1; scramble(ins); halt = 0; instr_valid = 1;
                if (ins.rst_in_mem && i == 1) begin
                    reset_n = 0;
                    nextCycle();
                    reset_n = 1;
                    exp_pc = '0; exp_retired = 0; exp_halted = 0;
                    next_pc = '0; next_ret = 0;
                    checkOutput("state_after_mem_reset", 32'(dut.state), 32'(IDLE));
                    return;
                end
                if (i == ins.mem_wait) dmem_ready = 1;
            end
        end
        nextCycle();
        scramble(ins); halt = 0; dmem_ready = 1;
        exp_reg_write = !(ins.branch || ins.jump || ins.mem_write);
        next_pc = modelNextPc(exp_pc, ins);
        next_ret = satAdd(exp_retired, 65535);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n = 0; start = 0; instr_valid = 0; dmem_ready = 0; halt = 0; branch = 0;
        jump = 0; mem_read = 0; mem_write = 0; take_branch = 0; jump_target = '0; branch_off = '0;
        exp_fetch_req = 0; exp_ir_load = 0; exp_dmem_req = 0; exp_reg_write = 0; exp_halted = 0;
        exp_pc = '0; exp_retired = 0; next_pc = '0; next_ret = 0;
        repeat (2) @(posedge clk);
        #1;
        check_en = 1;
        checkOutput("reset_state", 32'(dut.state), 32'(IDLE));
        checkOutput("reset_pc", 32'(pc), 32'd0);
        checkOutput("reset_fetch_req", 32'(fetch_req), 32'd0);
        nextCycle(); reset_n = 1;
        nextCycle();

        startRun();
        rw_hi = 0;
        applyStimulus(nop());
        settleFetch();
        checkOutput("alu_pc", 32'(pc), 32'd1);
        checkOutput("alu_retired", 32'(retired), 32'd1);
        checkOutput("alu_reg_write_pulses", 32'(rw_hi), 32'd1);

        dmem_hi = 0; rw_hi = 0;
        op = nop(); op.mem_read = 1; op.mem_wait = 3;
        applyStimulus(op);
        settleFetch();
        checkOutput("load_dmem_req_cycles", 32'(dmem_hi), 32'd4);
        checkOutput("load_reg_write_pulses", 32'(rw_hi), 32'd1);
        checkOutput("load_pc", 32'(pc), 32'd2);

        op = nop(); op.mem_write = 1; op.fetch_wait = 2;
        applyStimulus(op);
        applyStimulus(nop());
        applyStimulus(nop());
        settleFetch();
        checkOutput("pc_before_branch", 32'(pc), 32'd5);

        op = nop(); op.branch = 1; op.take = 1; op.off = 6'b111101;
        applyStimulus(op);
        settleFetch();
        checkOutput("branch_taken_pc", 32'(pc), 32'd2);
        for (int i = 0; i < 3; i++) applyStimulus(nop());
        op.take = 0;
        applyStimulus(op);
        settleFetch();
        checkOutput("branch_not_taken_pc", 32'(pc), 32'd6);

        op = nop(); op.jump = 1; op.target = 10'd0;
        applyStimulus(op);
        op = nop(); op.branch = 1; op.take = 1; op.off = 6'b111111;
        applyStimulus(op);
        settleFetch();
        checkOutput("branch_wrap_pc", 32'(pc), 32'd1023);

        op = nop(); op.jump = 1; op.branch = 1; op.take = 1; op.target = 10'd100; op.off = 6'b111101;
        applyStimulus(op);
        settleFetch();
        checkOutput("jump_over_branch_pc", 32'(pc), 32'd100);

        op = nop(); op.jump = 1; op.target = 10'd1023;
        applyStimulus(op);
        applyStimulus(nop());
        settleFetch();
        checkOutput("increment_wrap_pc", 32'(pc), 32'd0);
        applyStimulus(nop());

        op = nop(); op.halt = 1;
        applyStimulus(op);
        for (int i = 0; i < 3; i++) begin
            nextCycle(); instr_valid = 1; dmem_ready = 1;
        end
        checkOutput("halt_halted", 32'(halted), 32'd1);
        checkOutput("halt_pc_held", 32'(pc), 32'd1);
        checkOutput("halt_retired", 32'(retired), 32'd17);
        checkOutput("sat_retired_pinned", 32'(s_retired), 32'd7);

        startRun();
        settleFetch();
        checkOutput("restart_fetch_req", 32'(fetch_req), 32'd1);
        checkOutput("restart_pc", 32'(pc), 32'd0);
        checkOutput("restart_retired", 32'(retired), 32'd0);
        applyStimulus(nop());

        op = nop(); op.mem_read = 1; op.mem_wait = 5; op.rst_in_mem = 1;
        applyStimulus(op);
        checkOutput("mem_reset_dmem_req", 32'(dmem_req), 32'd0);
        nextCycle();
        checkOutput("mem_reset_idle_fetch_req", 32'(fetch_req), 32'd0);

        startRun();
        applyStimulus(nop());
        settleFetch();
        checkOutput("recover_pc", 32'(pc), 32'd1);
        checkOutput("recover_retired", 32'(retired), 32'd1);
        nextCycle(); instr_valid = 1; exp_fetch_req = 1; exp_ir_load = 1;
        nextCycle();
        check_en = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/exec_sequencer.md
# exec_sequencer

Multi-cycle instruction sequencer for the 141L core. Owns the program counter and steps each instruction through fetch, decode, execute, optional data-memory access and writeback. It consumes the registered branch/jump/halt/memRead/memWrite strobes from the control decoder, and drives instruction-memory fetch, data-memory requests and register-file write enable.

## Interface
- PC_WIDTH, 10: program counter width (instruction memory depth 2^PC_WIDTH)
- OFF_WIDTH, 6: signed branch offset width
- CNT_WIDTH, 16: retired-instruction counter width

- clk  in  1  clock; all state changes on posedge
- reset_n  in  1  synchronous, active-low reset
- start  in  1  begin execution at PC 0 (sampled in IDLE and HALTED)
- fetch_req  out  1  instruction fetch request, held until instr_valid
- instr_valid  in  1  instruction memory data valid
- ir_load  out  1  one-cycle pulse: latch instruction register
- pc  out  PC_WIDTH  current program counter
- branch, jump, halt, mem_read, mem_write  in  1 each  decoder strobes, valid in EXEC
- take_branch  in  1  branch condition from datapath
- jump_target  in  PC_WIDTH  absolute jump address
- branch_off  in  OFF_WIDTH  signed PC-relative offset
- dmem_req  out  1  data-memory request, held until dmem_ready
- dmem_ready  in  1  data-memory access complete
- reg_write  out  1  one-cycle register-file write enable
- halted  out  1  core stopped
- retired  out  CNT_WIDTH  retired-instruction count, saturating

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED.
- IDLE: all strobes 0. start=1 -> FETCH, pc<=0, retired<=0.
- FETCH: fetch_req=1. instr_valid=1 -> ir_load pulse in the same cycle -> DECODE. Otherwise stay.
- DECODE: exactly one cycle, so the registered decoder can update -> EXEC.
- EXEC: priority halt > memory > other.
  - halt=1 -> HALTED; pc holds; retired increments.
  - else mem_read|mem_write -> MEM.
  - else -> WB.
- MEM: dmem_req=1 until dmem_ready=1 -> WB. There is no timeout.
- WB (one cycle):
  - reg_write=1 unless branch, jump or mem_write was sampled in EXEC.
  - pc update: jump -> jump_target; else branch&take_branch -> pc + sign-extended branch_off, modulo 2^PC_WIDTH; else pc+1, wrapping max->0.
  - jump wins if jump and branch are both set.
  - retired increments, saturating at all-ones.
  - -> FETCH.
- HALTED: halted=1, all other strobes 0. start=1 -> FETCH with pc<=0, retired<=0.
- Strobe sampling: decoder strobes, take_branch, jump_target and branch_off are captured in EXEC into internal registers. Changes to them during MEM do not affect WB.
- instr_valid outside FETCH and dmem_ready outside MEM are ignored.

## Timing
- Reset: state=IDLE, pc=0, retired=0, fetch_req=ir_load=dmem_req=reg_write=halted=0. This applies from the first edge with reset_n=0 and overrides any state, including mid-FETCH and mid-MEM; requests drop immediately.
- Minimum instruction latency (instr_valid and dmem_ready same-cycle):
  - ALU/branch/jump: 4 cycles (FETCH, DECODE, EXEC, WB).
  - memory: 5 cycles.
- fetch_req rises the cycle after entering FETCH from WB, IDLE or HALTED. It falls the cycle after instr_valid.
- New pc is visible the cycle after WB, coincident with fetch_req.
- reg_write is never asserted in the same cycle as dmem_req.

## Structure
- Shared package exec_seq_pkg:
  - state enum: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED
  - default PC_WIDTH/OFF_WIDTH/CNT_WIDTH constants
- Sub-module pc_next_calc: combinational next-PC computation (jump/branch/increment, sign extension, wrap). It is instantiated once and unit-testable alone.

## Test plan
- Reset then start, ALU op, instr_valid and dmem_ready immediate -> pc 0->1 after 4 cycles, reg_write single pulse in WB, retired=1.
- Load with dmem_ready delayed 3 cycles -> dmem_req high 4 cycles, reg_write pulse follows, instruction takes 8 cycles.
- Branch cases at pc=5, branch_off=-3:
  - take_branch=1 -> pc=2, reg_write=0.
  - take_branch=0 -> pc=6.
  - pc=0, offset -1 -> pc=1023.
- jump=1 and branch=1 together, jump_target=100 -> pc=100. Then pc=1023 ALU op -> pc=0.
- halt in EXEC -> halted=1, pc held, retired increments; start -> pc=0, retired=0, fetch_req next cycle.
- reset_n=0 during MEM with dmem_req=1 -> next cycle all outputs at reset values, state IDLE; retired saturation forced at 0xFFFF stays 0xFFFF after another instruction.
